mips_bus_lsu: RTL and testbench
===============================

# mips_bus_lsu

Parametrised load/store unit between the pipelined MIPS core and the Avalon memory-mapped bus. It queues load and store requests in a FIFO and issues them to the bus one at a time, honouring `waitrequest`. It generates `byteenable` and lane-aligned `writedata` for byte, halfword and word accesses, and returns sign- or zero-extended load data tagged with the destination register. It replaces per-instruction memory stalls in the core with request/response handshakes, so the pipeline stalls only when the queue is full.

## Interface
Parameters:
- `FIFO_DEPTH`, 4, request queue entries; power of two, ≥2.
- `TAG_W`, 5, width of the destination tag carried from request to response.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: queue can accept; equals `count != FIFO_DEPTH`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_signed` in 1: sign-extend load data (LB/LH); ignored for word and stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_tag` in TAG_W: destination tag.
- `rsp_valid` out 1: one-cycle pulse; no backpressure.
- `rsp_data` out 32: extended load data; 0 for error responses.
- `rsp_tag` out TAG_W: tag of the completing request.
- `rsp_err` out 1: misaligned-access response (only with the macro defined).
- `idle` out 1: queue empty and no bus transfer in progress.
- `address` out 32: Avalon word address, `{addr[31:2],2'b00}`.
- `read`, `write` out 1: Avalon commands.
- `waitrequest` in 1: slave stall.
- `writedata` out 32, `byteenable` out 4, `readdata` in 32: Avalon data.

## Operation
- Request accepted when `req_valid && req_ready`; it is written at the FIFO tail, and `count` increments.
- There is no bypass, and no push when full, even if a pop happens in the same cycle.
- Lane mapping: byte at address offset k occupies bits `[8k+7:8k]`, enabled by `byteenable[k]`.
- Byte access: enable `4'b0001 << a[1:0]`; store data is `{4{wdata[7:0]}}`.
- Half access: enable `4'b0011 << a[1:0]`; store data is `{2{wdata[15:0]}}`.
- Word access: enable `4'b1111`; store data is `wdata`.
- Loads extract the addressed lane and right-justify it. They sign-extend if `req_signed`, otherwise zero-extend.
- FSM has two states:
  - IDLE: if `count > 0`, load the head onto the bus registers and go to BUS.
  - BUS: hold `address`, `read`/`write`, `byteenable` and `writedata` stable while `waitrequest = 1`.
  - When `waitrequest = 0`, the transfer completes and the head is popped.
  - On completion, the unit issues the next entry in the following cycle if one exists, otherwise it returns to IDLE.
- Responses:
  - A load completion captures `readdata` and asserts `rsp_valid` the following cycle with data and tag.
  - Stores produce no response.
- In BUS state `read` and `write` are mutually exclusive; outside BUS both are 0.

## Timing
- Reset values:
  - state IDLE, `count` 0, pointers 0.
  - `read`/`write` 0.
  - `address`, `byteenable`, `writedata` all 0.
  - `rsp_valid`/`rsp_err` 0, `rsp_data`/`rsp_tag` 0.
  - `idle` 1, `req_ready` 1.
- Reset mid-transfer drops the bus command in the same edge and discards all queued entries.
- Latency:
  - Request accepted at cycle N gives the bus command at N+1.
  - With zero wait, `rsp_valid` is at N+2.
  - Each wait cycle adds one.
- Throughput: with `waitrequest` held at 0, one transfer per cycle back-to-back.
- Pointers wrap modulo FIFO_DEPTH; `count` is log2(FIFO_DEPTH)+1 bits wide.
- Push and pop in the same cycle leave `count` unchanged.
- `idle` = (state IDLE) && (`count` == 0); it is combinational from registers.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A head entry with a misaligned address (half with `a[0]`, word with `a[1:0] != 0`) is not issued to the bus.
  - It is popped in one cycle and produces `rsp_valid = 1`, `rsp_err = 1`, `rsp_data = 0` and its tag, for loads and stores alike.
- Undefined:
  - `rsp_err` is tied to 0.
  - Misaligned addresses are force-aligned: half uses `a[1]` only, word ignores `a[1:0]`.

## Test plan
- Reset, then SW addr 0x10 data 0x11223344, waitrequest 0 -> `write = 1`, `address = 0x10`, `byteenable = 4'hF`, `writedata = 0x11223344` one cycle after accept; no `rsp_valid`.
- LB addr 0x13, signed, readdata 0x80FFFFFF -> `byteenable = 4'h8`; `rsp_data = 0xFFFFFF80`, tag echoed, two cycles after accept. LBU on the same data -> `0x00000080`.
- LH addr 0x22 with waitrequest high for 3 cycles -> bus signals stable for 4 cycles; `rsp_valid` at accept+5; `byteenable = 4'hC`.
- Push FIFO_DEPTH+1 requests with waitrequest stuck high -> `req_ready` falls after FIFO_DEPTH accepts. Release -> FIFO_DEPTH back-to-back transfers in FIFO_DEPTH cycles, then `idle = 1`.
- With `LSU_MISALIGN_TRAP_EN`, LW addr 0x02 -> no `read`; `rsp_err = 1`, `rsp_data = 0`. Without the macro -> `read` at `address = 0x00`.
- Assert reset during BUS state with 3 queued entries -> `read = 0` next cycle, `idle = 1`, no responses emitted.

Source files
------------

// File: rtl/mips_bus_lsu.sv
// rtl/mips_bus_lsu.sv - MIPS load/store unit queueing requests onto an Avalon-MM bus
//
// Purpose: buffers load/store requests in a FIFO and issues them one at a time
// to an Avalon-MM slave. It generates byteenable and lane-replicated writedata,
// and returns extended load data tagged with the destination register.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word heads are not issued; they return an error response
//   undefined : misaligned addresses are force-aligned; rsp_err is tied to 0
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake (ready = queue not full)
//   req_write/size/signed/addr/wdata/tag  request fields
//   rsp_valid/rsp_data/rsp_tag/rsp_err    one-cycle response pulse
//   idle                            queue empty and no transfer in progress
//   address/read/write/waitrequest/writedata/byteenable/readdata  Avalon-MM master
module mips_bus_lsu #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             idle,
    output logic [31:0]      address,
    output logic             read,
    output logic             write,
    input  logic             waitrequest,
    output logic [31:0]      writedata,
    output logic [3:0]       byteenable,
    input  logic [31:0]      readdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BUS} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;

    logic              write_mem_q  [FIFO_DEPTH];
    logic [1:0]        size_mem_q   [FIFO_DEPTH];
    logic              signed_mem_q [FIFO_DEPTH];
    logic [31:0]       addr_mem_q   [FIFO_DEPTH];
    logic [31:0]       wdata_mem_q  [FIFO_DEPTH];
    logic [TAG_W-1:0]  tag_mem_q    [FIFO_DEPTH];

    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;
    logic [TAG_W-1:0]  rsp_tag_q;

    logic              push, pop;
    logic              head_write, head_signed, head_mis;
    logic [1:0]        head_size, head_off;
    logic [31:0]       head_addr, head_wdata, head_lane_wdata, head_load;
    logic [TAG_W-1:0]  head_tag;
    logic [3:0]        head_be;
    logic [31:0]       rd_shift;
    logic              is_byte, is_half;

    assign head_write  = write_mem_q[rd_ptr_q];
    assign head_size   = size_mem_q[rd_ptr_q];
    assign head_signed = signed_mem_q[rd_ptr_q];
    assign head_addr   = addr_mem_q[rd_ptr_q];
    assign head_wdata  = wdata_mem_q[rd_ptr_q];
    assign head_tag    = tag_mem_q[rd_ptr_q];

    // Size 3 falls through to word handling.
    assign is_byte = (head_size == 2'd0);
    assign is_half = (head_size == 2'd1);

`ifdef LSU_MISALIGN_TRAP_EN
    assign head_mis = (is_half && head_addr[0]) || (!is_byte && !is_half && (head_addr[1:0] != 2'b00));
`else
    assign head_mis = 1'b0;
`endif

    // Lane offset; without the trap, half ignores a[0] and word ignores a[1:0].
    always_comb begin
        head_off        = 2'b00;
        head_be         = 4'b1111;
        head_lane_wdata = head_wdata;
        if (is_byte) begin
            head_off        = head_addr[1:0];
            head_be         = 4'b0001 << head_addr[1:0];
            head_lane_wdata = {4{head_wdata[7:0]}};
        end else if (is_half) begin
            head_off        = {head_addr[1], 1'b0};
            head_be         = 4'b0011 << {head_addr[1], 1'b0};
            head_lane_wdata = {2{head_wdata[15:0]}};
        end
    end

    // Right-justify the addressed lane, then extend.
    assign rd_shift = readdata >> {head_off, 3'b000};
    always_comb begin
        head_load = readdata;
        if (is_byte) begin
            head_load = {{24{head_signed & rd_shift[7]}}, rd_shift[7:0]};
        end else if (is_half) begin
            head_load = {{16{head_signed & rd_shift[15]}}, rd_shift[15:0]};
        end
    end

    assign req_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    // The in-flight transfer is always the FIFO head; a trapped head retires without a bus cycle.
    assign pop       = (state_q == BUS) && (head_mis || !waitrequest);
    assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

    // BUS is entered on the same edge that makes the queue non-empty, so the
    // command appears the cycle after accept.
    always_comb begin
        state_d    = state_q;
        read       = 1'b0;
        write      = 1'b0;
        address    = 32'h0;
        byteenable = 4'h0;
        writedata  = 32'h0;
        case (state_q)
            IDLE: if (count_d != '0) state_d = BUS;
            BUS: begin
                if (!head_mis) begin
                    read       = !head_write;
                    write      = head_write;
                    address    = {head_addr[31:2], 2'b00};
                    byteenable = head_be;
                    writedata  = head_lane_wdata;
                end
                if (count_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rsp_valid_q <= pop && (head_mis || !head_write);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pop && (head_mis || !head_write)) begin
                rsp_data_q <= head_mis ? 32'h0 : head_load;
                rsp_tag_q  <= head_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            write_mem_q[wr_ptr_q]  <= req_write;
            size_mem_q[wr_ptr_q]   <= req_size;
            signed_mem_q[wr_ptr_q] <= req_signed;
            addr_mem_q[wr_ptr_q]   <= req_addr;
            wdata_mem_q[wr_ptr_q]  <= req_wdata;
            tag_mem_q[wr_ptr_q]    <= req_tag;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic rsp_err_q;
    always_ff @(posedge clk) begin
        if (reset) rsp_err_q <= 1'b0;
        else       rsp_err_q <= pop && head_mis;
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign idle      = (state_q == IDLE) && (count_q == '0);
endmodule

// File: tb/tb_mips_bus_lsu.sv
// tb/tb_mips_bus_lsu.sv - directed self-checking bench for mips_bus_lsu
module tb_mips_bus_lsu;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        rsp_valid, rsp_err, idle, read, write, waitrequest;
    logic [31:0] rsp_data, address, writedata, readdata;
    logic [4:0]  rsp_tag;
    logic [3:0]  byteenable;

    int errors = 0;
    int checks = 0;

    mips_bus_lsu #(.FIFO_DEPTH(DEPTH), .TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .idle(idle), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed just after the edge, outputs checked #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
        req_valid = v; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d; req_tag = t;
    endtask

    initial begin
        reset = 1'b1; waitrequest = 1'b0; readdata = 32'h0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick(); tick();
        #1;
        chk("rst_read", {31'b0, read}, 32'd0);
        chk("rst_write", {31'b0, write}, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_address", address, 32'h0);
        chk("rst_be", {28'b0, byteenable}, 32'h0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_tag", {27'b0, rsp_tag}, 32'h0);
        reset = 1'b0;
        tick();

        // SW 0x10
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 5'd1);
        tick();
        req_valid = 1'b0; #1;
        chk("sw_write", {31'b0, write}, 32'd1);
        chk("sw_read", {31'b0, read}, 32'd0);
        chk("sw_address", address, 32'h10);
        chk("sw_be", {28'b0, byteenable}, 32'hF);
        chk("sw_wdata", writedata, 32'h11223344);
        tick(); #1;
        chk("sw_no_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("sw_idle", {31'b0, idle}, 32'd1);
        chk("sw_write_off", {31'b0, write}, 32'd0);

        // LB 0x13 signed
        readdata = 32'h80FFFFFF;
        drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 5'd5);
        tick();
        req_valid = 1'b0; #1;
        chk("lb_read", {31'b0, read}, 32'd1);
        chk("lb_address", address, 32'h10);
        chk("lb_be", {28'b0, byteenable}, 32'h8);
        chk("lb_rsp_early", {31'b0, rsp_valid}, 32'd0);
        tick(); #1;
        chk("lb_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("lb_rsp_data", rsp_data, 32'hFFFFFF80);
        chk("lb_rsp_tag", {27'b0, rsp_tag}, 32'd5);

        // LBU same data
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5'd6);
        tick();
        req_valid = 1'b0; #1;
        chk("lbu_rsp_gap", {31'b0, rsp_valid}, 32'd0);
        tick(); #1;
        chk("lbu_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("lbu_rsp_data", rsp_data, 32'h00000080);
        chk("lbu_rsp_tag", {27'b0, rsp_tag}, 32'd6);
        tick(); #1;
        chk("lbu_rsp_pulse", {31'b0, rsp_valid}, 32'd0);

        // LH 0x22 unsigned, 3 wait cycles
        readdata = 32'hABCD1234;
        waitrequest = 1'b1;
        drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 5'd9);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lh_wait_read", {31'b0, read}, 32'd1);
            chk("lh_wait_addr", address, 32'h20);
            chk("lh_wait_be", {28'b0, byteenable}, 32'hC);
            chk("lh_wait_norsp", {31'b0, rsp_valid}, 32'd0);
            tick();
        end
        waitrequest = 1'b0; #1;
        chk("lh_last_read", {31'b0, read}, 32'd1);
        chk("lh_last_be", {28'b0, byteenable}, 32'hC);
        tick(); #1;
        chk("lh_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("lh_rsp_data", rsp_data, 32'h0000ABCD);
        chk("lh_rsp_tag", {27'b0, rsp_tag}, 32'd9);
        chk("lh_read_off", {31'b0, read}, 32'd0);

        // Fill queue with waitrequest stuck high
        waitrequest = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 5'(i));
            #1;
            chk("fill_ready", {31'b0, req_ready}, 32'd1);
            tick();
        end
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h50, 32'hFF, 5'd7);
        #1;
        chk("full_ready", {31'b0, req_ready}, 32'd0);
        chk("full_head_addr", address, 32'h40);
        tick();
        req_valid = 1'b0;
        waitrequest = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("drain_write", {31'b0, write}, 32'd1);
            chk("drain_addr", address, 32'h40 + 32'(4 * i));
            chk("drain_wdata", writedata, 32'hA0 + 32'(i));
            tick();
        end
        #1;
        chk("drain_idle", {31'b0, idle}, 32'd1);
        chk("drain_write_off", {31'b0, write}, 32'd0);

        // LW 0x02 misaligned
        readdata = 32'hCAFEBABE;
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 5'd3);
        tick();
        req_valid = 1'b0; #1;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_no_read", {31'b0, read}, 32'd0);
        tick(); #1;
        chk("mis_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("mis_rsp_err", {31'b0, rsp_err}, 32'd1);
        chk("mis_rsp_data", rsp_data, 32'h0);
        chk("mis_rsp_tag", {27'b0, rsp_tag}, 32'd3);
`else
        chk("mis_read", {31'b0, read}, 32'd1);
        chk("mis_address", address, 32'h0);
        chk("mis_be", {28'b0, byteenable}, 32'hF);
        tick(); #1;
        chk("mis_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("mis_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("mis_rsp_data", rsp_data, 32'hCAFEBABE);
        chk("mis_rsp_tag", {27'b0, rsp_tag}, 32'd3);
`endif
        tick();

        // Reset during BUS with 3 queued loads
        waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 5'(10 + i));
            tick();
        end
        req_valid = 1'b0; #1;
        chk("pre_rst_read", {31'b0, read}, 32'd1);
        chk("pre_rst_idle", {31'b0, idle}, 32'd0);
        reset = 1'b1;
        tick(); #1;
        chk("mid_rst_read", {31'b0, read}, 32'd0);
        chk("mid_rst_idle", {31'b0, idle}, 32'd1);
        chk("mid_rst_norsp", {31'b0, rsp_valid}, 32'd0);
        reset = 1'b0;
        waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("post_rst_norsp", {31'b0, rsp_valid}, 32'd0);
            chk("post_rst_read", {31'b0, read}, 32'd0);
            chk("post_rst_idle", {31'b0, idle}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
